// File: rtl/imm_materializer.sv
// -----------------------------------------------------------------------------
// imm_materializer
//
// Turns a 32-bit constant plus a destination register into the shortest MIPS
// I-type sequence that loads it: addiu, ori, lui, or lui followed by ori.
// Destination $0 always produces a single nop. Words are streamed out one per
// handshake.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       asynchronous active-low reset
//   flush       synchronous abort of any sequence in progress
//   req_valid   request present
//   req_ready   block can accept a request (high only in IDLE)
//   req_value   constant to materialise
//   req_rt      destination register number
//   ins_valid   ins_word valid
//   ins_ready   downstream accepts ins_word
//   ins_word    emitted instruction word
//   ins_last    ins_word is the final word of its sequence
//   word_count  words handed off (ins_valid && ins_ready), wraps
// -----------------------------------------------------------------------------
module imm_materializer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_value,
    input  logic [4:0]       req_rt,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [31:0]      ins_word,
    output logic             ins_last,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

    state_t           state_q, state_d;
    logic [31:0]      value_q, value_d;
    logic [4:0]       rt_q, rt_d;
    logic             two_q, two_d;
    logic             ins_valid_q, ins_valid_d;
    logic [31:0]      ins_word_q, ins_word_d;
    logic             ins_last_q, ins_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      plan_word;
    logic             plan_two;
    logic             handshake;

    // First word of the plan and whether a second (ori) word follows.
    always_comb begin
        plan_word = 32'h0000_0000;
        plan_two  = 1'b0;
        if (req_rt == 5'd0) begin
            plan_word = 32'h0000_0000;
        end else if ((&req_value[31:15]) || !(|req_value[31:15])) begin
            // Value is the sign extension of its low half.
            plan_word = {OP_ADDIU, 5'd0, req_rt, req_value[15:0]};
        end else if (req_value[31:16] == 16'h0000) begin
            plan_word = {OP_ORI, 5'd0, req_rt, req_value[15:0]};
        end else if (req_value[15:0] == 16'h0000) begin
            plan_word = {OP_LUI, 5'd0, req_rt, req_value[31:16]};
        end else begin
            plan_word = {OP_LUI, 5'd0, req_rt, req_value[31:16]};
            plan_two  = 1'b1;
        end
    end

    assign handshake = ins_valid_q && ins_ready;

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        rt_d        = rt_q;
        two_d       = two_q;
        ins_valid_d = ins_valid_q;
        ins_word_d  = ins_word_q;
        ins_last_d  = ins_last_q;
        cnt_d       = cnt_q;

        // Handoffs count even when a flush discards the rest of the sequence.
        if (handshake) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (flush) begin
            state_d     = IDLE;
            ins_valid_d = 1'b0;
            ins_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        value_d     = req_value;
                        rt_d        = req_rt;
                        two_d       = plan_two;
                        ins_word_d  = plan_word;
                        ins_last_d  = !plan_two;
                        ins_valid_d = 1'b1;
                        state_d     = EMIT1;
                    end
                end
                EMIT1: begin
                    if (handshake) begin
                        if (two_q) begin
                            ins_word_d = {OP_ORI, rt_q, rt_q, value_q[15:0]};
                            ins_last_d = 1'b1;
                            state_d    = EMIT2;
                        end else begin
                            ins_valid_d = 1'b0;
                            ins_last_d  = 1'b0;
                            state_d     = IDLE;
                        end
                    end
                end
                EMIT2: begin
                    if (handshake) begin
                        ins_valid_d = 1'b0;
                        ins_last_d  = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    ins_valid_d = 1'b0;
                    ins_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            value_q     <= 32'h0000_0000;
            rt_q        <= 5'd0;
            two_q       <= 1'b0;
            ins_valid_q <= 1'b0;
            ins_word_q  <= 32'h0000_0000;
            ins_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            rt_q        <= rt_d;
            two_q       <= two_d;
            ins_valid_q <= ins_valid_d;
            ins_word_q  <= ins_word_d;
            ins_last_q  <= ins_last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign ins_valid  = ins_valid_q;
    assign ins_word   = ins_word_q;
    assign ins_last   = ins_last_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_imm_materializer.sv
// -----------------------------------------------------------------------------
// tb_imm_materializer
//
// Directed and random requests against a reference that derives the load
// sequence from the instruction-field arithmetic. A second instance with a
// 2-bit counter shares every input so counter wrap is checked continuously.
// -----------------------------------------------------------------------------
module tb_imm_materializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_value = 32'h0;
    logic [4:0]  req_rt = 5'd0;
    logic        ins_ready = 1'b0;

    logic        req_ready, ins_valid, ins_last;
    logic [31:0] ins_word;
    logic [15:0] word_count;

    logic        req_ready2, ins_valid2, ins_last2;
    logic [31:0] ins_word2;
    logic [1:0]  word_count2;

    int vectors = 0;
    int miscompares = 0;
    int model_count = 0;

    imm_materializer #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_value(req_value), .req_rt(req_rt),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_word(ins_word), .ins_last(ins_last),
        .word_count(word_count)
    );

    imm_materializer #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready2),
        .req_value(req_value), .req_rt(req_rt),
        .ins_valid(ins_valid2), .ins_ready(ins_ready),
        .ins_word(ins_word2), .ins_last(ins_last2),
        .word_count(word_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return 32'((op * 67108864) + (rs * 2097152) + (rt * 65536) + imm);
    endfunction

    // Reference: shortest sequence chosen from the value's numeric properties.
    task automatic model_plan(input logic [31:0] value, input logic [4:0] rt,
                              output logic [31:0] w0, output logic [31:0] w1, output int n);
        int lo, hi, slo;
        lo  = int'(value % 65536);
        hi  = int'(value / 65536);
        slo = (lo >= 32768) ? lo - 65536 : lo;
        w1  = 32'h0;
        n   = 1;
        if (rt == 0)                  w0 = 32'h0;
        else if (32'(slo) == value)   w0 = itype(9, 0, rt, lo);
        else if (hi == 0)             w0 = itype(13, 0, rt, lo);
        else if (lo == 0)             w0 = itype(15, 0, rt, hi);
        else begin
            w0 = itype(15, 0, rt, hi);
            w1 = itype(13, rt, rt, lo);
            n  = 2;
        end
    endtask

    task automatic chk_count();
        chk("word_count", {16'h0, word_count}, 32'(model_count % 65536));
        chk("word_count_w2", {30'h0, word_count2}, 32'(model_count % 4));
    endtask

    // Full request: accept, then each word held for `stall` cycles before ready.
    task automatic do_req(input logic [31:0] value, input logic [4:0] rt, input int stall);
        logic [31:0] w [2];
        int n;
        model_plan(value, rt, w[0], w[1], n);
        chk("req_ready_pre", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_value = value;
        req_rt    = rt;
        ins_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        req_value = $urandom;
        req_rt    = 5'($urandom);
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < stall; s++) begin
                chk("stall_valid", {31'h0, ins_valid}, 32'h1);
                chk("stall_word", ins_word, w[i]);
                tick();
            end
            ins_ready = 1'b1;
            chk("ins_valid", {31'h0, ins_valid}, 32'h1);
            chk("ins_word", ins_word, w[i]);
            chk("ins_last", {31'h0, ins_last}, 32'(i == n - 1));
            chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
            tick();
            model_count++;
            ins_ready = 1'b0;
        end
        chk("done_valid", {31'h0, ins_valid}, 32'h0);
        chk("req_ready_post", {31'h0, req_ready}, 32'h1);
        chk_count();
    endtask

    initial begin
        logic [31:0] v;
        logic [4:0]  r;
        int kind;

        // Reset state
        #1;
        chk("rst_valid", {31'h0, ins_valid}, 32'h0);
        chk("rst_word", ins_word, 32'h0);
        chk("rst_last", {31'h0, ins_last}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk_count();
        tick();
        reset = 1'b1;
        tick();

        // Directed single-word forms and the two-word stall case
        do_req(32'h0000_1234, 5'd8, 0);
        do_req(32'hFFFF_8000, 5'd8, 1);
        do_req(32'h0000_ABCD, 5'd8, 0);
        do_req(32'h1234_0000, 5'd8, 2);
        do_req(32'h1234_5678, 5'd8, 3);
        do_req(32'h1234_5678, 5'd0, 0);
        do_req(32'h0000_0000, 5'd31, 0);
        do_req(32'hFFFF_FFFF, 5'd1, 0);

        // ins_ready while idle has no effect
        ins_ready = 1'b1;
        tick();
        tick();
        ins_ready = 1'b0;
        chk("idle_ready_valid", {31'h0, ins_valid}, 32'h0);
        chk_count();

        // Async reset while in EMIT2
        req_valid = 1'b1; req_value = 32'h1234_5678; req_rt = 5'd8;
        tick();
        req_valid = 1'b0;
        ins_ready = 1'b1;
        tick();
        model_count++;
        ins_ready = 1'b0;
        chk("emit2_word", ins_word, 32'h3508_5678);
        #2;
        reset = 1'b0;
        #1;
        model_count = 0;
        chk("arst_valid", {31'h0, ins_valid}, 32'h0);
        chk("arst_word", ins_word, 32'h0);
        chk("arst_last", {31'h0, ins_last}, 32'h0);
        chk_count();
        tick();
        reset = 1'b1;
        tick();
        chk("arst_req_ready", {31'h0, req_ready}, 32'h1);
        do_req(32'h8765_4321, 5'd9, 1);

        // Flush in EMIT1 without handshake
        req_valid = 1'b1; req_value = 32'h1234_5678; req_rt = 5'd8;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'h0, ins_valid}, 32'h0);
        chk("flush_last", {31'h0, ins_last}, 32'h0);
        chk("flush_req_ready", {31'h0, req_ready}, 32'h1);
        chk_count();

        // Flush coinciding with a handshake still counts the word
        req_valid = 1'b1; req_value = 32'hDEAD_BEEF; req_rt = 5'd3;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        ins_ready = 1'b1;
        tick();
        model_count++;
        flush = 1'b0;
        ins_ready = 1'b0;
        chk("flush_hs_valid", {31'h0, ins_valid}, 32'h0);
        chk_count();

        // Flush beats a request in IDLE
        flush = 1'b1;
        req_valid = 1'b1; req_value = 32'h0000_0001; req_rt = 5'd4;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_noacc_valid", {31'h0, ins_valid}, 32'h0);
        chk("flush_noacc_ready", {31'h0, req_ready}, 32'h1);

        // Random requests across all plan shapes
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 4);
            v = $urandom;
            unique case (kind)
                0: v = v & 32'h0000_7FFF;
                1: v = v | 32'hFFFF_8000;
                2: v = v & 32'h0000_FFFF;
                3: v = v & 32'hFFFF_0000;
                default: ;
            endcase
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            do_req(v, r, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_materializer.md
Name: imm_materializer

Overview:
- Reverse of the decode-side immediate extender: takes an arbitrary 32-bit constant plus a destination register and emits the shortest MIPS I-type sequence that loads it (addiu / ori / lui / lui+ori).
- Used by the boot/instruction-generation path to stream instruction words into instruction memory or the fetch stage.
- Input and output sides both use valid/ready handshakes.

Parameters:
CNT_W, 16, width of the emitted-word statistics counter (wraps modulo 2^CNT_W).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
flush  input  1  synchronous abort of any sequence in progress
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_value  input  32  constant to materialise
req_rt  input  5  destination register number
ins_valid  output  1  ins_word valid
ins_ready  input  1  downstream accepts ins_word
ins_word  output  32  emitted instruction word
ins_last  output  1  ins_word is the final word of the sequence
word_count  output  CNT_W  total words handed off (ins_valid && ins_ready)

Behaviour:
- Reset (reset == 0, asynchronous) forces state IDLE, ins_valid = 0, ins_word = 0, ins_last = 0, word_count = 0, and clears the latched value/rt. req_ready = 1 in IDLE, so it reads 1 once the FSM is in reset state.
- States: IDLE, EMIT1, EMIT2.
- req_ready = (state == IDLE), combinational from state. Accept occurs when req_valid && req_ready.
- IDLE, on accept: latch value and rt, compute the plan, go to EMIT1.
  - ins_valid, ins_word and ins_last are registered and appear the cycle after accept (latency 1).
  - Max throughput is one request per two cycles.
- Plan selection, first match wins (lo = value[15:0], hi = value[31:16]):
  1. rt == 0: single word 32'h00000000 (nop).
  2. value[31:15] all equal: {6'h09, 5'd0, rt, lo} (addiu rt,$0,lo), single word.
  3. hi == 0: {6'h0d, 5'd0, rt, lo} (ori rt,$0,lo), single word.
  4. lo == 0: {6'h0f, 5'd0, rt, hi} (lui rt,hi), single word.
  5. Otherwise two words: {6'h0f, 5'd0, rt, hi} then {6'h0d, rt, rt, lo}.
- EMIT1: hold ins_valid = 1 and ins_word/ins_last stable until ins_ready.
  - On handshake, single-word plan: ins_valid -> 0, go to IDLE.
  - On handshake, two-word plan: load the second word with ins_last = 1, go to EMIT2.
  - ins_last = 1 in EMIT1 only for single-word plans.
- EMIT2: hold the second word until ins_ready. On handshake: ins_valid -> 0, ins_last -> 0, go to IDLE.
- Back-to-back: no new request is accepted in the same cycle as the final handshake; req_ready rises the cycle after.
- word_count increments by 1 on every ins_valid && ins_ready and wraps from all-ones to 0. It is not cleared by flush.
- flush = 1: next edge goes to IDLE with ins_valid = 0 and ins_last = 0, and any sequence in progress is discarded.
  - If ins_ready is also high that cycle, the handshake still counts toward word_count.
  - flush has priority over accepting a new request: req_valid during flush in IDLE is not accepted.
- ins_ready asserted while ins_valid = 0 has no effect.
- req_value and req_rt are ignored except at accept.

Test Plan:
- rt=8, value 0x00001234 -> one word 0x24081234, ins_last=1, ins_valid the cycle after accept.
- rt=8, values 0xFFFF8000 / 0x0000ABCD / 0x12340000 -> 0x24088000 / 0x3408ABCD / 0x3C081234, each single word with ins_last=1.
- rt=8, value 0x12345678, ins_ready held low 3 cycles then high -> 0x3C081234 held stable (ins_last=0), then 0x35085678 (ins_last=1); req_ready=0 throughout, then 1 after; word_count += 2.
- rt=0, value 0x12345678 -> single word 0x00000000 with ins_last=1.
- Two-word request, then reset pulled low while in EMIT2 -> ins_valid, ins_word, ins_last and word_count are 0 immediately without a clock edge; req_ready=1 after release; next request behaves normally.
- flush in EMIT1 of a two-word plan with ins_ready=0 -> next cycle IDLE, ins_valid=0, word_count unchanged. Separately, CNT_W=2 with 5 emitted words -> word_count=1.
